// File: rtl/pwm_bank.sv
// pwm_bank: memory-mapped multi-channel PWM peripheral.
// A shared prescaled period counter drives CHANNELS duty comparators. Period and duty
// settings are double-buffered (pending -> active) and only change at a period boundary,
// while disabled, or one cycle after a LOAD write.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-low reset
//   write_enable bus write strobe
//   read_enable  bus read strobe
//   address      bus address; 16-word window at BASE_ADDR
//   write_data   bus write data
//   read_data    registered read data (0 after an unselected or absent read)
//   pulse        registered PWM outputs
//   period_tick  one-cycle strobe aligned with the counter-0 cycle after a wrap
module pwm_bank #(
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned WIDTH     = 8,
   parameter logic [15:0] BASE_ADDR = 16'h8000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                write_enable,
   input  logic                read_enable,
   input  logic [15:0]         address,
   input  logic [15:0]         write_data,
   output logic [15:0]         read_data,
   output logic [CHANNELS-1:0] pulse,
   output logic                period_tick
);

   logic                en_q, en_d;
   logic                inv_q, inv_d;
   logic                load_q, load_d;
   logic                status_q, status_d;
   logic                wrap_q, wrap_d;
   logic [WIDTH-1:0]    period_pend_q, period_pend_d;
   logic [WIDTH-1:0]    period_act_q, period_act_d;
   logic [WIDTH-1:0]    cnt_q, cnt_d;
   logic [15:0]         prescale_q, prescale_d;
   logic [15:0]         presc_cnt_q, presc_cnt_d;
   logic [15:0]         read_data_q, read_data_d;
   logic [CHANNELS-1:0] pulse_q, pulse_d;
   logic [WIDTH-1:0]    duty_pend_q [CHANNELS];
   logic [WIDTH-1:0]    duty_pend_d [CHANNELS];
   logic [WIDTH-1:0]    duty_act_q  [CHANNELS];
   logic [WIDTH-1:0]    duty_act_d  [CHANNELS];

   logic       sel, wr, rd;
   logic [3:0] offset;
   logic       step, wrap, shadow_load, run;

   assign sel    = (address[15:4] == BASE_ADDR[15:4]);
   assign offset = address[3:0];
   assign wr     = write_enable && sel;
   assign rd     = read_enable && sel;

   always_comb begin
      step        = en_q && (presc_cnt_q == prescale_q);
      wrap        = step && (cnt_q == period_act_q);
      // LOAD is applied from the registered flag, one cycle after the write.
      shadow_load = wrap || !en_q || load_q;
   end

   // Register writes and shadow copies.
   always_comb begin
      en_d          = en_q;
      inv_d         = inv_q;
      load_d        = 1'b0;
      status_d      = status_q;
      period_pend_d = period_pend_q;
      prescale_d    = prescale_q;
      duty_pend_d   = duty_pend_q;
      if (wr) begin
         case (offset)
            4'h0: begin
               en_d   = write_data[0];
               load_d = write_data[1];
               inv_d  = write_data[2];
            end
            4'h1: period_pend_d = write_data[WIDTH-1:0];
            4'h2: prescale_d    = write_data;
            4'h3: status_d      = 1'b0;
            default: begin
               for (int unsigned i = 0; i < CHANNELS; i++) begin
                  if (offset == 4'(i + 4)) duty_pend_d[i] = write_data[WIDTH-1:0];
               end
            end
         endcase
      end
      // A wrap in the same cycle as a STATUS write keeps the flag set.
      if (wrap) status_d = 1'b1;

      period_act_d = shadow_load ? period_pend_q : period_act_q;
      duty_act_d   = shadow_load ? duty_pend_q : duty_act_q;
   end

   // Prescaler, period counter and compare.
   always_comb begin
      // Enabling starts from 0 next cycle; disabling zeroes the counters at once.
      run         = en_q && en_d;
      presc_cnt_d = 16'd0;
      cnt_d       = '0;
      if (run) begin
         if (step) begin
            cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
         end else begin
            presc_cnt_d = presc_cnt_q + 16'd1;
            cnt_d       = cnt_q;
         end
      end
      wrap_d = wrap && en_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         pulse_d[i] = (en_q && (cnt_q < duty_act_q[i])) ^ inv_q;
      end
   end

   // Read mux; unselected or absent reads return 0.
   always_comb begin
      read_data_d = 16'd0;
      if (rd) begin
         case (offset)
            4'h0: read_data_d = {13'd0, inv_q, 1'b0, en_q};
            4'h1: read_data_d = 16'(period_pend_q);
            4'h2: read_data_d = prescale_q;
            4'h3: read_data_d = {15'd0, status_q};
            default: begin
               for (int unsigned i = 0; i < CHANNELS; i++) begin
                  if (offset == 4'(i + 4)) read_data_d = 16'(duty_pend_q[i]);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         en_q          <= 1'b0;
         inv_q         <= 1'b0;
         load_q        <= 1'b0;
         status_q      <= 1'b0;
         wrap_q        <= 1'b0;
         period_pend_q <= {WIDTH{1'b1}};
         period_act_q  <= {WIDTH{1'b1}};
         cnt_q         <= '0;
         prescale_q    <= 16'd0;
         presc_cnt_q   <= 16'd0;
         read_data_q   <= 16'd0;
         pulse_q       <= '0;
         duty_pend_q   <= '{default: '0};
         duty_act_q    <= '{default: '0};
      end else begin
         en_q          <= en_d;
         inv_q         <= inv_d;
         load_q        <= load_d;
         status_q      <= status_d;
         wrap_q        <= wrap_d;
         period_pend_q <= period_pend_d;
         period_act_q  <= period_act_d;
         cnt_q         <= cnt_d;
         prescale_q    <= prescale_d;
         presc_cnt_q   <= presc_cnt_d;
         read_data_q   <= read_data_d;
         pulse_q       <= pulse_d;
         duty_pend_q   <= duty_pend_d;
         duty_act_q    <= duty_act_d;
      end
   end

   assign read_data   = read_data_q;
   assign pulse       = pulse_q;
   assign period_tick = wrap_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed self-checking bench for pwm_bank (CHANNELS=4, WIDTH=8, BASE_ADDR=0x8000).
module tb_pwm_bank;

   localparam int CH = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          write_enable = 1'b0;
   logic          read_enable = 1'b0;
   logic [15:0]   address = 16'd0;
   logic [15:0]   write_data = 16'd0;
   logic [15:0]   read_data;
   logic [CH-1:0] pulse;
   logic          period_tick;

   int n_cmp = 0;
   int n_err = 0;
   int hi_cnt [CH];
   int tick_cnt;

   pwm_bank #(
      .CHANNELS (CH),
      .WIDTH    (8),
      .BASE_ADDR(16'h8000)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .write_enable(write_enable),
      .read_enable (read_enable),
      .address     (address),
      .write_data  (write_data),
      .read_data   (read_data),
      .pulse       (pulse),
      .period_tick (period_tick)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // All bus tasks start and end on a falling edge.
   task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
      address      = a;
      write_data   = d;
      write_enable = 1'b1;
      @(negedge clock);
      write_enable = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
      address     = a;
      read_enable = 1'b1;
      @(negedge clock);
      d           = read_data;
      read_enable = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic count_window(input int n);
      for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
      tick_cnt = 0;
      repeat (n) begin
         @(negedge clock);
         for (int c = 0; c < CH; c++) if (pulse[c]) hi_cnt[c]++;
         if (period_tick) tick_cnt++;
      end
   endtask

   task automatic check_window(input string tag, input int e0, input int e1, input int e2,
                               input int e3, input int et);
      check_eq({tag, "_p0"}, 32'(hi_cnt[0]), 32'(e0));
      check_eq({tag, "_p1"}, 32'(hi_cnt[1]), 32'(e1));
      check_eq({tag, "_p2"}, 32'(hi_cnt[2]), 32'(e2));
      check_eq({tag, "_p3"}, 32'(hi_cnt[3]), 32'(e3));
      check_eq({tag, "_ticks"}, 32'(tick_cnt), 32'(et));
   endtask

   // Returns the number of falling edges until period_tick is seen, or -1 on timeout.
   task automatic cycles_to_tick(input int limit, output int n);
      n = -1;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clock);
         if (period_tick) begin
            n = k;
            break;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rd;
      int          n;

      // Reset state.
      repeat (3) @(negedge clock);
      check_eq("rst_pulse", 32'(pulse), 32'h0);
      check_eq("rst_tick", 32'(period_tick), 32'h0);
      check_eq("rst_rdata", 32'(read_data), 32'h0);
      reset = 1'b1;
      @(negedge clock);
      for (int o = 0; o < 16; o++) begin
         bus_read(16'h8000 + 16'(o), rd);
         check_eq($sformatf("rst_reg%0d", o), 32'(rd), (o == 1) ? 32'hFF : 32'h0);
      end
      bus_read(16'h8001, rd);
      @(negedge clock);
      check_eq("idle_rdata_zero", 32'(read_data), 32'h0);

      // Basic PWM, PRESCALE=0.
      bus_write(16'h8001, 16'd9);
      bus_write(16'h8002, 16'd0);
      bus_write(16'h8004, 16'd3);
      bus_write(16'h8005, 16'd0);
      bus_write(16'h8006, 16'd10);
      bus_write(16'h8007, 16'd5);
      bus_write(16'h8000, 16'h0001);
      cycles_to_tick(100, n);
      check_eq("p0_first_tick", 32'(n), 32'd10);
      cycles_to_tick(100, n);
      check_eq("p0_tick_gap", 32'(n), 32'd10);
      bus_read(16'h8003, rd);
      check_eq("status_set", 32'(rd), 32'h1);
      count_window(20);
      check_window("p0_win", 6, 0, 20, 10, 2);

      // Disable, clear STATUS, check upper-bit truncation.
      bus_write(16'h8000, 16'h0000);
      bus_write(16'h8003, 16'h0000);
      bus_read(16'h8003, rd);
      check_eq("status_clear", 32'(rd), 32'h0);
      bus_write(16'h8001, 16'h1234);
      bus_read(16'h8001, rd);
      check_eq("period_trunc", 32'(rd), 32'h34);
      bus_write(16'h8001, 16'd9);

      // PRESCALE=3: 40-clock periods, then inverted outputs.
      bus_write(16'h8002, 16'd3);
      bus_write(16'h8000, 16'h0001);
      cycles_to_tick(200, n);
      check_eq("p3_first_tick", 32'(n), 32'd40);
      cycles_to_tick(200, n);
      check_eq("p3_tick_gap", 32'(n), 32'd40);
      count_window(40);
      check_window("p3_win", 12, 0, 40, 20, 1);
      bus_write(16'h8000, 16'h0005);
      wait_cycles(1);
      count_window(40);
      check_window("p3_inv_win", 28, 40, 0, 20, 1);
      bus_write(16'h8000, 16'h0004);
      wait_cycles(1);
      check_eq("dis_inv_pulse", 32'(pulse), 32'hF);
      check_eq("dis_tick", 32'(period_tick), 32'h0);

      // Mid-period duty change, then a change landing on the wrap edge.
      bus_write(16'h8000, 16'h0000);
      bus_write(16'h8002, 16'd0);
      bus_write(16'h8000, 16'h0001);
      count_window(4);
      check_eq("mid_pre_p0", 32'(hi_cnt[0]), 32'd3);
      bus_write(16'h8004, 16'd7);
      count_window(5);
      check_eq("mid_rest_p0", 32'(hi_cnt[0]), 32'd0);
      count_window(10);
      check_eq("mid_next_p0", 32'(hi_cnt[0]), 32'd7);
      check_eq("mid_next_tick", 32'(tick_cnt), 32'd1);
      wait_cycles(9);
      bus_write(16'h8004, 16'd2);
      count_window(10);
      check_eq("wrapwr_p0_old", 32'(hi_cnt[0]), 32'd7);
      count_window(10);
      check_eq("wrapwr_p0_new", 32'(hi_cnt[0]), 32'd2);

      // LOAD with a new period below the running counter.
      bus_write(16'h8000, 16'h0000);
      bus_write(16'h8000, 16'h0001);
      wait_cycles(5);
      bus_write(16'h8001, 16'd3);
      bus_write(16'h8000, 16'h0003);
      cycles_to_tick(400, n);
      check_eq("load_first_tick", 32'(n), 32'd253);
      cycles_to_tick(20, n);
      check_eq("load_gap1", 32'(n), 32'd4);
      cycles_to_tick(20, n);
      check_eq("load_gap2", 32'(n), 32'd4);
      count_window(8);
      check_window("load_win", 4, 0, 8, 8, 2);
      bus_read(16'h8000, rd);
      check_eq("ctrl_load_reads0", 32'(rd), 32'h1);

      // Reset mid-period with outputs high.
      check_eq("pre_rst_p2", 32'(pulse[2]), 32'h1);
      reset = 1'b0;
      @(negedge clock);
      check_eq("midrst_pulse", 32'(pulse), 32'h0);
      check_eq("midrst_tick", 32'(period_tick), 32'h0);
      check_eq("midrst_rdata", 32'(read_data), 32'h0);
      reset = 1'b1;
      @(negedge clock);
      bus_read(16'h8000, rd);
      check_eq("midrst_ctrl", 32'(rd), 32'h0);
      bus_read(16'h8001, rd);
      check_eq("midrst_period", 32'(rd), 32'hFF);
      bus_read(16'h8002, rd);
      check_eq("midrst_presc", 32'(rd), 32'h0);
      bus_read(16'h8003, rd);
      check_eq("midrst_status", 32'(rd), 32'h0);
      bus_read(16'h8004, rd);
      check_eq("midrst_duty0", 32'(rd), 32'h0);
      bus_read(16'h8006, rd);
      check_eq("midrst_duty2", 32'(rd), 32'h0);

      // Out-of-window and unmapped offsets.
      bus_write(16'h8020, 16'h0005);
      bus_write(16'h8021, 16'h0003);
      bus_write(16'h8008, 16'h00AA);
      bus_read(16'h8020, rd);
      check_eq("oow_read", 32'(rd), 32'h0);
      bus_read(16'h8000, rd);
      check_eq("oow_ctrl", 32'(rd), 32'h0);
      bus_read(16'h8001, rd);
      check_eq("oow_period", 32'(rd), 32'hFF);
      bus_read(16'h8008, rd);
      check_eq("unmapped_8", 32'(rd), 32'h0);
      wait_cycles(3);
      check_eq("oow_pulse", 32'(pulse), 32'h0);
      check_eq("oow_tick", 32'(period_tick), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Memory-mapped, multi-channel PWM peripheral for the NBBSOC bus: one shared period counter with programmable prescaler drives CHANNELS independent duty comparators. All period and duty settings are double-buffered and take effect only at a period boundary, so software updates never produce a truncated or glitched cycle. Sits on the CPU data-memory bus (address / write_enable / read_enable / write_data / read_data) alongside RAM and the other MMIO peripherals. It replaces the single fixed 8-bit PWM.

## Interface
- CHANNELS, 4, number of PWM outputs (1..8)
- WIDTH, 8, counter/period/duty width in bits (2..16)
- BASE_ADDR, 16'h8000, base of the 16-word decoded window (low 4 bits must be zero)

- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-low reset
- write_enable  in  1  bus write strobe
- read_enable  in  1  bus read strobe
- address  in  16  bus address; block responds to BASE_ADDR..BASE_ADDR+15
- write_data  in  16  bus write data
- read_data  out  16  registered read data
- pulse  out  CHANNELS  registered PWM outputs
- period_tick  out  1  one-cycle strobe at each period wrap

## Operation
- Register map (offset = address[3:0]):
  - 0x0 CTRL: bit0 EN, bit1 LOAD (write-1 self-clearing, reads 0), bit2 INV (invert all pulse outputs). Other bits are 0.
  - 0x1 PERIOD: pending period, WIDTH bits.
  - 0x2 PRESCALE: 16 bits; the counter advances once every PRESCALE+1 clocks.
  - 0x3 STATUS: bit0 WRAP sticky flag; any write clears it.
  - 0x4+i DUTY[i] for i < CHANNELS: pending duty, WIDTH bits. Offsets for i ≥ CHANNELS and offsets 0xC..0xF read 0, and writes to them are ignored.
- Upper unused bits of written values are discarded. Reads return zero-extended values.
- Shadowing: PERIOD and DUTY writes land in pending registers. Active registers copy all pending values together at:
  - a wrap,
  - any cycle with EN=0, or
  - the cycle after a LOAD write.
- Prescaler: a 16-bit counter runs 0..PRESCALE and asserts an internal step when it equals PRESCALE, then returns to 0.
- Main counter: on step, if counter == active period, it wraps to 0; otherwise it increments.
- Wrap event: step && counter == active period. On a wrap:
  - period_tick = 1 for that one cycle,
  - STATUS.WRAP sets,
  - shadow load occurs.
- Compare: raw[i] = EN && (counter < active_duty[i]).
  - duty = 0 gives constant low.
  - duty > period gives constant high.
  - Otherwise high time = duty × (PRESCALE+1) clocks per (period+1) × (PRESCALE+1)-clock cycle.
- pulse[i] = raw[i] XOR INV, registered.
- EN=0 behaviour:
  - prescaler and counter held at 0,
  - period_tick = 0,
  - pulse = INV replicated,
  - active registers track pending registers every cycle.
- Writing EN=1 starts counting from 0 on the next cycle.
- Write in the same cycle as a wrap: the active register loads the old pending value; the new value applies at the next wrap.
- STATUS write in the same cycle as a wrap: set wins, so WRAP=1.
- Bus accesses outside the window have no effect. read_data is 0 in the cycle after an unselected or absent read.

## Timing
- Reset (reset=0 at a clock edge):
  - counter, prescaler, CTRL, PRESCALE, STATUS, and all duties (pending and active) go to 0,
  - PERIOD pending and active go to 2^WIDTH-1,
  - pulse = 0, period_tick = 0, read_data = 0.
- Reset mid-period aborts immediately. There is no completion of the current cycle.
- Write latency: a register write at edge t is visible to readback at t+1.
- Read latency: read_enable and address sampled at edge t produce read_data valid after edge t+1. Simultaneous read and write to the same register returns the old value.
- pulse lags the counter by one clock, because the compare is registered. period_tick is asserted combinationally off the registered wrap, aligned with the counter-0 cycle.
- Shadowing boundaries:
  - A duty change applies exactly at the first counter==0 cycle after the next wrap.
  - A LOAD write at edge t makes active equal pending after edge t+1, without resetting the counter.
- If a new active period is less than the current counter value (possible only via LOAD), the counter continues to 2^WIDTH-1, wraps naturally to 0, then uses the new period.

## Test plan
- Reset, then read all offsets 0x0..0xF: PERIOD reads 0x00FF (WIDTH=8), STATUS 0, all others 0; pulse = 4'b0000.
- PERIOD=9, PRESCALE=0, DUTY0=3, DUTY1=0, DUTY2=10, DUTY3=5, EN=1:
  - pulse0 high 3 of every 10 clocks, pulse1 always low, pulse2 always high, pulse3 high 5 of every 10 clocks,
  - period_tick every 10 clocks,
  - STATUS=1 after the first wrap.
- Same setup with PRESCALE=3: period_tick every 40 clocks, pulse0 high for 12 clocks. Then write INV=1: every output is complemented.
- Mid-period write DUTY0=7 at counter=4: the current period still shows 3 high clocks, and the next period shows 7. Repeat with the write landing exactly on the wrap cycle: the change is delayed one extra period.
- Write PERIOD=3 then CTRL=EN|LOAD while counter=6 (old period 9): the counter runs to 255, wraps, and then repeats with 4-clock periods.
- Assert reset=0 mid-period with pulses high: all outputs 0 and registers at their reset values on the following edge. An access to 0x8020 changes nothing and reads 0.
